// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC router definitions. Flit codes, virtual-channel
//                state encodings and credit/VC sizing used across the router.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_SIZE  = 32;
    localparam int HEADER_LEN = 2;

    // Flit type carried in the flit header
    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    // Input virtual-channel state
    typedef enum logic [2:0] {
        VC_IDLE                = 3'd0,
        VC_ROUTING             = 3'd1,
        VC_WAITING_FOR_OVC     = 3'd2,
        VC_ACTIVE              = 3'd3,
        VC_WAITING_FOR_CREDITS = 3'd4
    } vc_state_e;

    // Credit and output-VC sizing; CREDIT_MAX must stay below 2**CREDIT_W
    localparam int CREDIT_W   = 3;
    localparam int CREDIT_MAX = 4;
    localparam int OVC_IDX_W  = 2;

    // True for flits that close a packet and therefore free their output VC
    function automatic logic is_last_flit(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Combinational one-hot grant searched
//                from a rotating pointer; pointer moves past the winner only
//                when the grant is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import noc_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_accept,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_lo_hit;
    logic             w_hi_hit;

    // Winner is the lowest request at/after the pointer, else the lowest overall (wrap)
    always_comb begin
        w_lo_hit = 1'b0;
        w_hi_hit = 1'b0;
        w_lo_idx = '0;
        w_hi_idx = '0;
        for (int c = N - 1; c >= 0; c--) begin
            if (i_req[c]) begin
                w_lo_hit = 1'b1;
                w_lo_idx = IDX_W'(c);
                if (IDX_W'(c) >= r_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi_idx = IDX_W'(c);
                end
            end
        end
    end

    assign w_idx      = w_hi_hit ? w_hi_idx : w_lo_idx;
    assign o_valid    = w_lo_hit;
    assign o_grant    = w_lo_hit ? (N'(1) << w_idx) : '0;
    assign w_next_ptr = (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + IDX_W'(1);

    // Advance the pointer past the winner on an accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept && o_valid) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ovc_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : ovc_credit_alloc
//  Description : Per-output-port VC allocator and credit tracker. Grants one
//                free output VC per cycle round-robin over waiting input VCs,
//                tracks one credit counter per output VC, frees a VC when
//                its packet's last flit leaves, flags protocol errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module ovc_credit_alloc
    import noc_pkg::*;
#(
    parameter  int NUM_IVC    = 4,
    parameter  int NUM_OVC    = 4,
    parameter  int CREDIT_MAX = noc_pkg::CREDIT_MAX,
    parameter  int CREDIT_W   = noc_pkg::CREDIT_W,
    localparam int c_ovc_w    = $clog2(NUM_OVC)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IVC-1:0]           req,
    output logic [NUM_IVC-1:0]           grant,
    output logic [c_ovc_w-1:0]           grant_ovc,
    input  logic                         sent_valid,
    input  logic [c_ovc_w-1:0]           sent_ovc,
    input  logic                         sent_tail,
    input  logic                         cred_valid,
    input  logic [c_ovc_w-1:0]           cred_ovc,
    output logic [NUM_OVC*CREDIT_W-1:0]  credit,
    output logic [NUM_OVC-1:0]           ovc_busy,
    output logic                         err
);

    logic [NUM_IVC-1:0] r_grant;
    logic [c_ovc_w-1:0] r_grant_ovc;
    logic [NUM_OVC-1:0] r_ovc_busy;
    logic               r_err;

    logic [NUM_IVC-1:0] w_eligible;
    logic [NUM_IVC-1:0] w_arb_grant;
    logic               w_arb_valid;
    logic               w_free_any;
    logic [c_ovc_w-1:0] w_free_idx;
    logic               w_alloc;
    logic [NUM_OVC-1:0] w_alloc_mask;
    logic [NUM_OVC-1:0] w_rel_mask;
    logic               w_sent_idle;
    logic [NUM_OVC-1:0] w_cred_err;

    // A requester being granted this cycle is masked so it cannot win twice
    assign w_eligible = req & ~r_grant;

    rr_arbiter #(
        .N (NUM_IVC)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_eligible),
        .i_accept (w_free_any),
        .o_grant  (w_arb_grant),
        .o_valid  (w_arb_valid)
    );

    // Lowest-index free output VC
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int k = NUM_OVC - 1; k >= 0; k--) begin
            if (!r_ovc_busy[k]) begin
                w_free_any = 1'b1;
                w_free_idx = c_ovc_w'(k);
            end
        end
    end

    assign w_alloc      = w_free_any && w_arb_valid;
    assign w_alloc_mask = w_alloc ? (NUM_OVC'(1) << w_free_idx) : '0;
    assign w_rel_mask   = (sent_valid && sent_tail) ? (NUM_OVC'(1) << sent_ovc) : '0;
    // Any departure on an unallocated VC (including a release) is a protocol error
    assign w_sent_idle  = sent_valid && !r_ovc_busy[sent_ovc];

    // Allocation, release and sticky error state. A released VC is busy at
    // this edge, so it can never be the one being allocated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_ovc <= '0;
            r_ovc_busy  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_grant     <= w_alloc ? w_arb_grant : '0;
            r_grant_ovc <= w_alloc ? w_free_idx  : '0;
            r_ovc_busy  <= (r_ovc_busy & ~w_rel_mask) | w_alloc_mask;
            if (w_sent_idle || (|w_cred_err)) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_OVC; k++) begin : g_credit
        logic [CREDIT_W-1:0] r_cnt;
        logic                w_dec;
        logic                w_inc;
        logic                w_at_zero;
        logic                w_at_max;

        assign w_dec     = sent_valid && (sent_ovc == c_ovc_w'(k));
        assign w_inc     = cred_valid && (cred_ovc == c_ovc_w'(k));
        assign w_at_zero = (r_cnt == '0);
        assign w_at_max  = (r_cnt == CREDIT_W'(CREDIT_MAX));
        assign w_cred_err[k] = (w_dec && !w_inc && w_at_zero) ||
                               (w_inc && !w_dec && w_at_max);

        // Saturating credit counter; simultaneous send and return cancel out
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= CREDIT_W'(CREDIT_MAX);
            end else if (w_dec && !w_inc && !w_at_zero) begin
                r_cnt <= r_cnt - CREDIT_W'(1);
            end else if (w_inc && !w_dec && !w_at_max) begin
                r_cnt <= r_cnt + CREDIT_W'(1);
            end
        end

        assign credit[k*CREDIT_W +: CREDIT_W] = r_cnt;
    end

    assign grant     = r_grant;
    assign grant_ovc = r_grant_ovc;
    assign ovc_busy  = r_ovc_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ovc_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ovc_credit_alloc
//  Description : Self-checking bench for ovc_credit_alloc: directed vector
//                table, hand-written reset/credit corner sequence, and a
//                randomized phase checked against a rule-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ovc_credit_alloc;

    localparam int NIVC = 4;
    localparam int NOVC = 4;
    localparam int CMAX = 4;
    localparam int CW   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NIVC-1:0]  req = '0;
    logic [NIVC-1:0]  grant;
    logic [1:0]       grant_ovc;
    logic             sent_valid = 1'b0;
    logic [1:0]       sent_ovc = '0;
    logic             sent_tail = 1'b0;
    logic             cred_valid = 1'b0;
    logic [1:0]       cred_ovc = '0;
    logic [NOVC*CW-1:0] credit;
    logic [NOVC-1:0]  ovc_busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ovc_credit_alloc #(
        .NUM_IVC    (NIVC),
        .NUM_OVC    (NOVC),
        .CREDIT_MAX (CMAX),
        .CREDIT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_ovc  (grant_ovc),
        .sent_valid (sent_valid),
        .sent_ovc   (sent_ovc),
        .sent_tail  (sent_tail),
        .cred_valid (cred_valid),
        .cred_ovc   (cred_ovc),
        .credit     (credit),
        .ovc_busy   (ovc_busy),
        .err        (err)
    );

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic       sv;
        logic [1:0] so;
        logic       st;
        logic       cv;
        logic [1:0] co;
        logic [3:0] eg;
        logic [1:0] egv;
        logic [3:0] eb;
        logic       ee;
        logic [11:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic sv,
                                input logic [1:0] so, input logic st, input logic cv,
                                input logic [1:0] co, input logic [3:0] eg,
                                input logic [1:0] egv, input logic [3:0] eb,
                                input logic ee, input logic [11:0] ec);
        vec_t v;
        v.r = r; v.q = q; v.sv = sv; v.so = so; v.st = st; v.cv = cv; v.co = co;
        v.eg = eg; v.egv = egv; v.eb = eb; v.ee = ee; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present inputs, let one rising edge pass, settle just after it
    task automatic cyc(input logic r, input logic [3:0] q, input logic sv, input logic [1:0] so,
                       input logic st, input logic cv, input logic [1:0] co);
        rst = r; req = q; sent_valid = sv; sent_ovc = so; sent_tail = st;
        cred_valid = cv; cred_ovc = co;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] egv,
                           input logic chk_gv, input logic [3:0] eb, input logic ee,
                           input logic [11:0] ec);
        chk({tag, "_grant"}, int'(grant), int'(eg));
        if (chk_gv) chk({tag, "_grant_ovc"}, int'(grant_ovc), int'(egv));
        chk({tag, "_busy"}, int'(ovc_busy), int'(eb));
        chk({tag, "_err"}, int'(err), int'(ee));
        chk({tag, "_credit"}, int'(credit), int'(ec));
    endtask

    // Rule-level reference model
    int         m_cred[NOVC];
    logic [3:0] m_busy;
    logic [3:0] m_grant;
    int         m_gvc;
    int         m_ptr;
    logic       m_err;

    task automatic model_step(input logic r, input logic [3:0] q, input logic sv, input logic [1:0] so,
                              input logic st, input logic cv, input logic [1:0] co);
        logic [3:0] nb;
        int isel, vsel, c;
        if (r) begin
            for (int k = 0; k < NOVC; k++) m_cred[k] = CMAX;
            m_busy = '0; m_grant = '0; m_gvc = 0; m_ptr = 0; m_err = 1'b0;
            return;
        end
        isel = -1; vsel = -1;
        for (int v = NOVC - 1; v >= 0; v--) if (!m_busy[v]) vsel = v;
        if (vsel >= 0) begin
            for (int k = 0; k < NIVC; k++) begin
                c = (m_ptr + k) % NIVC;
                if (isel < 0 && q[c] && !m_grant[c]) isel = c;
            end
        end
        nb = m_busy;
        if (sv && !m_busy[so]) m_err = 1'b1;
        if (sv && st) nb[so] = 1'b0;
        if (isel >= 0) begin
            nb[vsel] = 1'b1;
            m_grant  = 4'(1 << isel);
            m_gvc    = vsel;
            m_ptr    = (isel + 1) % NIVC;
        end else begin
            m_grant = '0;
        end
        m_busy = nb;
        for (int k = 0; k < NOVC; k++) begin
            if (sv && so == 2'(k) && !(cv && co == 2'(k))) begin
                if (m_cred[k] == 0) m_err = 1'b1; else m_cred[k] = m_cred[k] - 1;
            end else if (cv && co == 2'(k) && !(sv && so == 2'(k))) begin
                if (m_cred[k] == CMAX) m_err = 1'b1; else m_cred[k] = m_cred[k] + 1;
            end
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] pref);
        int c;
        c = $urandom_range(0, 3);
        if (pref != 4'b0 && $urandom_range(0, 9) != 0) begin
            while (!pref[c]) c = (c + 1) % 4;
        end
        return 2'(c);
    endfunction

    initial begin
        logic       r, sv, st, cv;
        logic [3:0] q, cpref;
        logic [1:0] so, co;

        // Reset and idle
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 12'h924));
        for (int n = 0; n < 5; n++)
            tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 12'h924));
        // Single requester, then drops
        tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 12'h924));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 12'h924));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 12'h924));
        // All requesting, round robin until output VCs run out
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 12'h924));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 12'h924));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0010, 1, 4'b0011, 0, 12'h924));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0100, 2, 4'b0111, 0, 12'h924));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b1000, 3, 4'b1111, 0, 12'h924));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h924));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h924));
        // Tail on VC2 frees it; allocation follows one cycle later
        tbl.push_back(mk(0, 4'b0100, 1, 2, 1, 0, 0, 4'b0000, 0, 4'b1011, 0, 12'h8E4));
        tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 0, 4'b0100, 2, 4'b1111, 0, 12'h8E4));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h8E4));
        // Drain VC1 credits, underflow, then send+return cancel, then a return
        tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h8DC));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h8D4));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h8CC));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b1111, 0, 12'h8C4));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b1111, 1, 12'h8C4));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 1, 1, 4'b0000, 0, 4'b1111, 1, 12'h8C4));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 1, 4'b0000, 0, 4'b1111, 1, 12'h8CC));

        for (int n = 0; n < tbl.size(); n++) begin
            cyc(tbl[n].r, tbl[n].q, tbl[n].sv, tbl[n].so, tbl[n].st, tbl[n].cv, tbl[n].co);
            chk_all($sformatf("vec%0d", n), tbl[n].eg, tbl[n].egv,
                    (tbl[n].eg != 4'b0) || tbl[n].r, tbl[n].eb, tbl[n].ee, tbl[n].ec);
        end

        // Credit overflow on VC0, then reset in the middle of a packet
        cyc(1, 4'b0000, 0, 0, 0, 0, 0);
        chk_all("ovf_rst", 4'b0000, 0, 1, 4'b0000, 0, 12'h924);
        cyc(0, 4'b0000, 0, 0, 0, 1, 0);
        chk_all("ovf", 4'b0000, 0, 0, 4'b0000, 1, 12'h924);
        cyc(0, 4'b0001, 0, 0, 0, 0, 0);
        chk_all("pkt_grant", 4'b0001, 0, 1, 4'b0001, 1, 12'h924);
        cyc(0, 4'b0000, 1, 0, 0, 0, 0);
        chk_all("pkt_head", 4'b0000, 0, 0, 4'b0001, 1, 12'h923);
        cyc(1, 4'b0000, 0, 0, 0, 0, 0);
        chk_all("mid_rst", 4'b0000, 0, 1, 4'b0000, 0, 12'h924);
        cyc(0, 4'b0000, 0, 0, 0, 0, 0);
        chk_all("post_rst", 4'b0000, 0, 0, 4'b0000, 0, 12'h924);
        // Releasing an unallocated VC is an error but still consumes a credit
        cyc(0, 4'b0000, 1, 3, 1, 0, 0);
        chk_all("idle_rel", 4'b0000, 0, 0, 4'b0000, 1, 12'h724);

        // Randomized phase against the model
        cyc(1, 4'b0000, 0, 0, 0, 0, 0);
        model_step(1, 4'b0000, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            q  = 4'($urandom_range(0, 15));
            sv = ($urandom_range(0, 1) == 1);
            so = pick(m_busy);
            st = ($urandom_range(0, 2) == 0);
            cpref = '0;
            for (int k = 0; k < NOVC; k++) cpref[k] = (m_cred[k] < CMAX);
            cv = ($urandom_range(0, 1) == 1);
            co = pick(cpref);
            cyc(r, q, sv, so, st, cv, co);
            model_step(r, q, sv, so, st, cv, co);
            chk("rnd_grant", int'(grant), int'(m_grant));
            if (m_grant != 4'b0) chk("rnd_grant_ovc", int'(grant_ovc), m_gvc);
            chk("rnd_busy", int'(ovc_busy), int'(m_busy));
            chk("rnd_err", int'(err), int'(m_err));
            for (int k = 0; k < NOVC; k++)
                chk($sformatf("rnd_credit%0d", k), int'(credit[k*CW +: CW]), m_cred[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
